// File: rtl/sr_latch_dff_bank.sv
// Bank of independent NOR-style SR latches with an XOR parity tap, plus one
// rising-edge D flip-flop. All state clears on the shared async active-low reset.
module sr_latch_dff_bank #(
    parameter int NUM_LATCHES       = 8,
    parameter bit FORBIDDEN_RESOLVE = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_LATCHES-1:0] s,
    input  logic [NUM_LATCHES-1:0] r,
    output logic [NUM_LATCHES-1:0] q,
    output logic [NUM_LATCHES-1:0] qn,
    output logic                   parity,
    input  logic                   d,
    output logic                   dq
);

    logic [NUM_LATCHES-1:0] state;

    for (genvar i = 0; i < NUM_LATCHES; i++) begin : g_latch
        // Stored value tracks the inputs while either is active, so when both
        // drop together from s=r=1 the latch closes on FORBIDDEN_RESOLVE.
        always_latch begin
            if (!rst_n) begin
                state[i] <= 1'b0;
            end else if (s[i] | r[i]) begin
                state[i] <= (s[i] & r[i]) ? FORBIDDEN_RESOLVE : s[i];
            end
        end

        always_comb begin
            q[i]  = state[i];
            qn[i] = ~state[i];
            if (!rst_n) begin
                q[i]  = 1'b0;
                qn[i] = 1'b1;
            end else if (s[i] & r[i]) begin
                q[i]  = 1'b0;
                qn[i] = 1'b0;
            end else if (s[i] | r[i]) begin
                q[i]  = s[i];
                qn[i] = ~s[i];
            end
        end
    end

    assign parity = ^q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dq <= 1'b0;
        end else begin
            dq <= d;
        end
    end

endmodule

// File: tb/tb_sr_latch_dff_bank.sv
// Directed bench for sr_latch_dff_bank: two instances share stimulus, one per
// FORBIDDEN_RESOLVE value, so both forbidden-exit outcomes are observed.
module tb_sr_latch_dff_bank;

    logic       clk;
    logic       rst_n;
    logic [7:0] s;
    logic [7:0] r;
    logic       d_val;
    logic       use_parity;
    logic       flop_d;
    logic [7:0] q0, qn0, q1, qn1;
    logic       parity0, parity1, dq0, dq1;

    int tests_run;
    int tests_failed;

    assign flop_d = use_parity ? parity0 : d_val;

    sr_latch_dff_bank #(.NUM_LATCHES(8), .FORBIDDEN_RESOLVE(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .s(s), .r(r), .q(q0), .qn(qn0),
        .parity(parity0), .d(flop_d), .dq(dq0)
    );

    sr_latch_dff_bank #(.NUM_LATCHES(8), .FORBIDDEN_RESOLVE(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .s(s), .r(r), .q(q1), .qn(qn1),
        .parity(parity1), .d(flop_d), .dq(dq1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        s            = 8'hFF;
        r            = 8'h00;
        d_val        = 1'b1;
        use_parity   = 1'b0;

        // Reset holds everything clear despite active set and running clock
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_q0", q0, 8'h00);
        check("rst_qn0", qn0, 8'hFF);
        check("rst_q1", q1, 8'h00);
        check("rst_dq", dq0, 1'b0);
        check("rst_parity", parity0, 1'b0);
        s = 8'h00;
        #1;
        rst_n = 1'b1;
        #1;
        check("release_q0", q0, 8'h00);

        s = 8'h05;
        #1;
        check("set_q", q0, 8'h05);
        check("set_qn", qn0, 8'hFA);
        check("set_parity", parity0, 1'b0);
        s = 8'h00;
        #1;
        check("hold_q", q0, 8'h05);
        r = 8'h01;
        #1;
        check("reset_bit0_q", q0, 8'h04);
        check("reset_bit0_parity", parity0, 1'b1);
        r = 8'h00;

        // Forbidden state and simultaneous exit into hold
        s = 8'hFF;
        r = 8'hFF;
        #1;
        check("forbid_q0", q0, 8'h00);
        check("forbid_qn0", qn0, 8'h00);
        check("forbid_qn1", qn1, 8'h00);
        s = 8'h00;
        r = 8'h00;
        #1;
        check("resolve0_q", q0, 8'h00);
        check("resolve0_qn", qn0, 8'hFF);
        check("resolve1_q", q1, 8'hFF);
        check("resolve1_qn", qn1, 8'h00);
        check("resolve1_parity", parity1, 1'b0);
        r = 8'hFF;
        #1;
        r = 8'h00;
        #1;
        check("cleared_q1", q1, 8'h00);

        // Flop latency and mid-cycle data changes
        @(negedge clk);
        d_val = 1'b1;
        @(posedge clk);
        #1;
        check("flop_d1", dq0, 1'b1);
        #2;
        d_val = 1'b0;
        #1;
        check("flop_midcycle_hold", dq0, 1'b1);
        @(posedge clk);
        #1;
        check("flop_d0", dq0, 1'b0);
        @(negedge clk);
        d_val = 1'b1;
        @(posedge clk);
        #1;
        check("flop_d1_again", dq0, 1'b1);
        check("flop_inst1", dq1, 1'b1);

        // Asynchronous reset between edges, released on a clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_dq", dq0, 1'b0);
        d_val = 1'b1;
        @(posedge clk);
        rst_n <= 1'b1;
        #1;
        check("release_edge_no_capture", dq0, 1'b0);
        @(posedge clk);
        #1;
        check("first_capture_after_release", dq0, 1'b1);

        // Parity fed back into the flop
        @(negedge clk);
        use_parity = 1'b1;
        s = 8'h07;
        #1;
        s = 8'h00;
        #1;
        check("chain_q07", q0, 8'h07);
        check("chain_parity1", parity0, 1'b1);
        @(posedge clk);
        #1;
        check("chain_dq1", dq0, 1'b1);
        r = 8'h04;
        #1;
        r = 8'h00;
        #1;
        check("chain_q03", q0, 8'h03);
        check("chain_dq_before_edge", dq0, 1'b1);
        @(posedge clk);
        #1;
        check("chain_dq0", dq0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
